// File: rtl/sd_read_sequencer.sv
// sd_read_sequencer
//
// Purpose:
//   Sequences one sd_file_reader read. The reader is held in reset until a
//   read is started, then released. Its unthrottled outen/outbyte stream is
//   buffered in a show-ahead FIFO and re-presented downstream as a
//   valid/ready byte stream with a last flag. A no-data watchdog retries a
//   silent reader a bounded number of times before giving up.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   start, abort      begin a read (IDLE/DONE/ERROR only) / cancel and flush
//   rd_rstn           reader reset, low holds the reader in reset
//   rd_outen          reader byte strobe
//   rd_outbyte        reader byte
//   rd_endfile        reader end-of-file level
//   o_tvalid          downstream byte valid
//   o_tready          downstream ready
//   o_tdata           downstream byte
//   o_tlast           high with the final byte of the file
//   busy, done        status for LEDs
//   err_code          0 none, 1 timeout, 2 overflow (meaningful in ERROR)
//   byte_count        bytes written into the FIFO during this read
//   retry_count       watchdog retries used during this read
module sd_read_sequencer #(
  parameter int FIFO_AW     = 10,
  parameter int HOLD_CYC    = 16,
  parameter int TIMEOUT_CYC = 50000000,
  parameter int MAX_RETRY   = 3,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic             rd_rstn,
  input  logic             rd_outen,
  input  logic [7:0]       rd_outbyte,
  input  logic             rd_endfile,
  output logic             o_tvalid,
  input  logic             o_tready,
  output logic [7:0]       o_tdata,
  output logic             o_tlast,
  output logic             busy,
  output logic             done,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] byte_count,
  output logic [1:0]       retry_count
);

  localparam int DEPTH  = 1 << FIFO_AW;
  localparam int FCW    = FIFO_AW + 1;
  localparam int HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam int WD_W   = $clog2(TIMEOUT_CYC + 1);

  localparam logic [FCW-1:0]    FULL_CNT  = FCW'(DEPTH);
  localparam logic [FCW-1:0]    ONE_CNT   = FCW'(1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);
  localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(TIMEOUT_CYC - 1);
  localparam logic [1:0]        RETRY_MAX = 2'(MAX_RETRY);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_HOLD   = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_STREAM = 3'd3;
  localparam logic [2:0] S_DRAIN  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [2:0] S_ERROR  = 3'd6;

  logic [2:0]         state;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [WD_W-1:0]    wd_cnt;
  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FCW-1:0]     count;

  logic fifo_full;
  logic fifo_empty;
  logic accepting;
  logic wr_en;
  logic rd_en;
  logic overflow;
  logic timeout;

  // FIFO flags and the write/read strobes. Bytes are only taken while the
  // reader is live and before end-of-file; a strobe into a full FIFO is an
  // overflow even if a read drains an entry in the same cycle.
  assign fifo_full  = (count == FULL_CNT);
  assign fifo_empty = (count == '0);
  assign accepting  = (state == S_WAIT) || (state == S_STREAM);
  assign wr_en      = accepting && rd_outen && !fifo_full;
  assign overflow   = accepting && rd_outen && fifo_full;
  assign rd_en      = o_tvalid && o_tready;
  assign timeout    = accepting && !rd_outen && (wd_cnt == WD_LAST);

  // Downstream view of the FIFO head. The head entry cannot be overwritten
  // while it is presented, so data and last stay stable under backpressure.
  assign o_tvalid = ((state == S_STREAM) || (state == S_DRAIN)) && !fifo_empty;
  assign o_tdata  = mem[rd_ptr];
  assign o_tlast  = (state == S_DRAIN) && (count == ONE_CNT);

  // Status decoded straight from the state register.
  assign rd_rstn = accepting || (state == S_DRAIN);
  assign busy    = (state == S_HOLD) || accepting || (state == S_DRAIN);
  assign done    = (state == S_DONE);

  // FIFO storage. No reset: contents are qualified by the occupancy count.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= rd_outbyte;
    end
  end

  // Main sequencer: FIFO pointers, counters, watchdog and state. Later
  // assignments in this block deliberately override earlier ones, so the
  // flushes on start/overflow win over the ordinary pointer updates.
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      state       <= S_IDLE;
      hold_cnt    <= '0;
      wd_cnt      <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      err_code    <= 2'd0;
      byte_count  <= '0;
      retry_count <= 2'd0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + FIFO_AW'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + FIFO_AW'(1);
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + ONE_CNT;
        2'b01:   count <= count - ONE_CNT;
        default: count <= count;
      endcase
      if (wr_en && (byte_count != '1)) begin
        byte_count <= byte_count + CNT_W'(1);
      end

      // Holding the watchdog at zero through HOLD means every attempt
      // enters WAIT_DATA with a fresh timeout window.
      if (wr_en || (state == S_HOLD)) begin
        wd_cnt <= '0;
      end else if (accepting) begin
        wd_cnt <= wd_cnt + WD_W'(1);
      end

      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state       <= S_HOLD;
            hold_cnt    <= '0;
            err_code    <= 2'd0;
            byte_count  <= '0;
            retry_count <= 2'd0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
          end
        end
        S_HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state <= S_WAIT;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        S_WAIT, S_STREAM: begin
          if (overflow) begin
            state    <= S_ERROR;
            err_code <= 2'd2;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
          end else if (rd_endfile) begin
            state <= S_DRAIN;
          end else if (timeout) begin
            // Retrying after bytes went out would replay them downstream.
            if ((byte_count == '0) && (retry_count < RETRY_MAX)) begin
              retry_count <= retry_count + 2'd1;
              hold_cnt    <= '0;
              state       <= S_HOLD;
            end else begin
              state    <= S_ERROR;
              err_code <= 2'd1;
            end
          end else if (wr_en) begin
            state <= S_STREAM;
          end
        end
        S_DRAIN: begin
          if (fifo_empty || ((count == ONE_CNT) && rd_en)) begin
            state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_read_sequencer.sv
// tb_sd_read_sequencer
//
// Directed bench for sd_read_sequencer with a small FIFO, short hold and
// short watchdog. Each byte that should reach downstream is pushed into a
// scoreboard queue as {last, data}; an independent monitor pops and compares
// on every accepted beat, and flags any beat nobody expected.
module tb_sd_read_sequencer;

  localparam int FIFO_AW     = 3;
  localparam int HOLD_CYC    = 4;
  localparam int TIMEOUT_CYC = 100;
  localparam int MAX_RETRY   = 2;
  localparam int CNT_W       = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             abort;
  logic             rd_rstn;
  logic             rd_outen;
  logic [7:0]       rd_outbyte;
  logic             rd_endfile;
  logic             o_tvalid;
  logic             o_tready;
  logic [7:0]       o_tdata;
  logic             o_tlast;
  logic             busy;
  logic             done;
  logic [1:0]       err_code;
  logic [CNT_W-1:0] byte_count;
  logic [1:0]       retry_count;

  int         nChecks = 0;
  int         nFail   = 0;
  logic [8:0] sb[$];

  sd_read_sequencer #(
    .FIFO_AW(FIFO_AW),
    .HOLD_CYC(HOLD_CYC),
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .MAX_RETRY(MAX_RETRY),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .abort(abort),
    .rd_rstn(rd_rstn),
    .rd_outen(rd_outen),
    .rd_outbyte(rd_outbyte),
    .rd_endfile(rd_endfile),
    .o_tvalid(o_tvalid),
    .o_tready(o_tready),
    .o_tdata(o_tdata),
    .o_tlast(o_tlast),
    .busy(busy),
    .done(done),
    .err_code(err_code),
    .byte_count(byte_count),
    .retry_count(retry_count)
  );

  // 100 MHz-style free-running clock.
  always #5 clk = ~clk;

  // One comparison: counts it, and reports a line only when it differs.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one reader cycle (strobe, byte, end-of-file) and release it.
  task automatic applyStimulus(input logic en, input logic [7:0] b, input logic ef);
    rd_outen   = en;
    rd_outbyte = b;
    rd_endfile = ef;
    tick();
    rd_outen   = 1'b0;
    rd_endfile = 1'b0;
  endtask

  task automatic expectBeat(input logic [7:0] b, input logic last);
    sb.push_back({last, b});
  endtask

  task automatic pulseStart();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic waitRstnHigh(output int n);
    n = 0;
    while (!rd_rstn && n < 50) begin
      tick();
      n++;
    end
  endtask

  task automatic waitDone(output int n);
    n = 0;
    while (!done && n < 300) begin
      tick();
      n++;
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_rd_rstn"}, rd_rstn, 0);
    checkOutput({tag, "_tvalid"}, o_tvalid, 0);
    checkOutput({tag, "_tlast"}, o_tlast, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_err_code"}, err_code, 0);
    checkOutput({tag, "_byte_count"}, byte_count, 0);
    checkOutput({tag, "_retry_count"}, retry_count, 0);
  endtask

  // Scoreboard monitor: samples on the falling edge, where the handshake
  // that will complete on the next rising edge is already settled.
  initial begin
    logic [8:0] exp;
    forever begin
      @(negedge clk);
      if (!rst && o_tvalid && o_tready) begin
        if (sb.size() == 0) begin
          nChecks++;
          nFail++;
          $display("[TB] FAIL beat_unexpected: got data 0x%0h last %0d, expected no beat", o_tdata, o_tlast);
        end else begin
          exp = sb.pop_front();
          checkOutput("beat_data", o_tdata, exp[7:0]);
          checkOutput("beat_last", o_tlast, exp[8]);
        end
      end
    end
  end

  // Absolute time limit so a stuck run still ends with a report.
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "[TB] time limit reached");
  end

  // Directed sequence.
  initial begin
    int   n;
    int   falls;
    logic prev;

    rst        = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    rd_outen   = 1'b0;
    rd_outbyte = 8'h00;
    rd_endfile = 1'b0;
    o_tready   = 1'b0;
    repeat (3) tick();
    checkResetValues("por");
    rst = 1'b0;
    tick();

    $display("[TB] nominal read");
    pulseStart();
    checkOutput("nom_hold_rstn", rd_rstn, 0);
    checkOutput("nom_hold_busy", busy, 1);
    waitRstnHigh(n);
    checkOutput("nom_hold_cycles", n, HOLD_CYC);
    o_tready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      expectBeat(8'(8'h41 + i), (i == 4));
      applyStimulus(1'b1, 8'(8'h41 + i), (i == 4));
    end
    waitDone(n);
    checkOutput("nom_done", done, 1);
    checkOutput("nom_byte_count", byte_count, 5);
    checkOutput("nom_rd_rstn", rd_rstn, 0);
    checkOutput("nom_err_code", err_code, 0);
    checkOutput("nom_sb_empty", sb.size(), 0);

    $display("[TB] backpressure");
    pulseStart();
    waitRstnHigh(n);
    o_tready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      expectBeat(8'(8'h50 + i), (i == 7));
      applyStimulus(1'b1, 8'(8'h50 + i), 1'b0);
    end
    for (int k = 0; k < 3; k++) begin
      checkOutput("bp_stall_valid", o_tvalid, 1);
      checkOutput("bp_stall_data", o_tdata, 8'h50);
      tick();
    end
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("bp_drain_tlast", o_tlast, 0);
    o_tready = 1'b1;
    waitDone(n);
    checkOutput("bp_done", done, 1);
    checkOutput("bp_err_code", err_code, 0);
    checkOutput("bp_byte_count", byte_count, 8);
    checkOutput("bp_sb_empty", sb.size(), 0);

    $display("[TB] overflow");
    pulseStart();
    waitRstnHigh(n);
    o_tready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b1, 8'(8'h60 + i), 1'b0);
    end
    checkOutput("ov_err_code", err_code, 2);
    checkOutput("ov_tvalid", o_tvalid, 0);
    checkOutput("ov_busy", busy, 0);
    checkOutput("ov_byte_count", byte_count, 8);

    $display("[TB] timeout with retries exhausted");
    o_tready = 1'b1;
    pulseStart();
    checkOutput("to_err_cleared", err_code, 0);
    prev  = rd_rstn;
    falls = 0;
    n     = 0;
    while (busy && n < 1000) begin
      tick();
      n++;
      if (prev && !rd_rstn && busy) falls++;
      prev = rd_rstn;
    end
    checkOutput("to_rstn_repulses", falls, 2);
    checkOutput("to_err_code", err_code, 1);
    checkOutput("to_retry_count", retry_count, 2);
    checkOutput("to_done", done, 0);

    $display("[TB] timeout then data on second attempt");
    pulseStart();
    waitRstnHigh(n);
    n = 0;
    while (rd_rstn && n < 300) begin
      tick();
      n++;
    end
    checkOutput("rt_timeout_cycles", n, TIMEOUT_CYC);
    checkOutput("rt_retry_after_timeout", retry_count, 1);
    waitRstnHigh(n);
    expectBeat(8'h31, 1'b0);
    applyStimulus(1'b1, 8'h31, 1'b0);
    expectBeat(8'h32, 1'b1);
    applyStimulus(1'b1, 8'h32, 1'b1);
    waitDone(n);
    checkOutput("rt_done", done, 1);
    checkOutput("rt_retry_count", retry_count, 1);
    checkOutput("rt_byte_count", byte_count, 2);
    checkOutput("rt_err_code", err_code, 0);

    $display("[TB] empty file");
    pulseStart();
    waitRstnHigh(n);
    applyStimulus(1'b0, 8'h00, 1'b1);
    waitDone(n);
    checkOutput("ef_done", done, 1);
    checkOutput("ef_byte_count", byte_count, 0);
    checkOutput("ef_sb_empty", sb.size(), 0);

    $display("[TB] byte and end-of-file together");
    pulseStart();
    waitRstnHigh(n);
    expectBeat(8'h7A, 1'b1);
    applyStimulus(1'b1, 8'h7A, 1'b1);
    waitDone(n);
    checkOutput("eb_done", done, 1);
    checkOutput("eb_byte_count", byte_count, 1);
    checkOutput("eb_sb_empty", sb.size(), 0);

    $display("[TB] abort and start together");
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    checkOutput("as_busy", busy, 0);
    checkOutput("as_done", done, 0);

    $display("[TB] abort mid-stream");
    pulseStart();
    waitRstnHigh(n);
    o_tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 8'(8'h20 + i), 1'b0);
    end
    checkOutput("ab_pre_tvalid", o_tvalid, 1);
    checkOutput("ab_pre_byte_count", byte_count, 3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("ab_busy", busy, 0);
    checkOutput("ab_tvalid", o_tvalid, 0);
    checkOutput("ab_byte_count", byte_count, 0);
    checkOutput("ab_rd_rstn", rd_rstn, 0);
    o_tready = 1'b1;
    repeat (3) tick();
    checkOutput("ab_post_tvalid", o_tvalid, 0);

    $display("[TB] reset mid-drain");
    pulseStart();
    waitRstnHigh(n);
    o_tready = 1'b0;
    applyStimulus(1'b1, 8'h11, 1'b0);
    applyStimulus(1'b1, 8'h12, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("rd_pre_busy", busy, 1);
    checkOutput("rd_pre_tvalid", o_tvalid, 1);
    checkOutput("rd_pre_tlast", o_tlast, 0);
    rst = 1'b1;
    tick();
    checkResetValues("mid_rst");
    rst      = 1'b0;
    o_tready = 1'b1;
    repeat (3) tick();
    checkOutput("rd_post_tvalid", o_tvalid, 0);
    checkOutput("final_sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
